// File: rtl/CSR_Pkg.sv
// Machine-mode CSR types, trap cause codes and the trap priority order.
package CSR_Pkg;
  localparam logic [30:0] CAUSE_MSI              = 31'd3;
  localparam logic [30:0] CAUSE_MTI              = 31'd7;
  localparam logic [30:0] CAUSE_MEI              = 31'd11;
  localparam logic [30:0] CAUSE_FETCH_MISALIGNED = 31'd0;
  localparam logic [30:0] CAUSE_ILLEGAL          = 31'd2;
  localparam logic [30:0] CAUSE_EBREAK           = 31'd3;
  localparam logic [30:0] CAUSE_ECALL            = 31'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic {IDLE, FLUSH} trap_state_t;

  typedef struct packed {
    logic [18:0] wpri_hi;
    logic [1:0]  mpp;
    logic [2:0]  wpri_mid;
    logic        mpie;
    logic [2:0]  wpri_lo;
    logic        mie;
    logic [2:0]  wpri_0;
  } mstatus_t;

  typedef struct packed {
    logic meie;
    logic mtie;
    logic msie;
  } mie_m_only_t;

  typedef struct packed {
    logic meip;
    logic mtip;
    logic msip;
  } mip_m_only_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  // Interrupt priority: external, then software, then timer.
  function automatic logic [30:0] irq_code(input mie_m_only_t active);
    logic [30:0] code;
    if (active.meie)      code = CAUSE_MEI;
    else if (active.msie) code = CAUSE_MSI;
    else                  code = CAUSE_MTI;
    return code;
  endfunction

  function automatic logic [30:0] exc_code(input logic fetch_misaligned, input logic illegal,
                                           input logic ebreak);
    logic [30:0] code;
    if (fetch_misaligned) code = CAUSE_FETCH_MISALIGNED;
    else if (illegal)     code = CAUSE_ILLEGAL;
    else if (ebreak)      code = CAUSE_EBREAK;
    else                  code = CAUSE_ECALL;
    return code;
  endfunction
endpackage

// File: rtl/CoreConfig.sv
// Core-wide configuration constants.
// The PC is carried without its always-zero low bits.
package CoreConfig;
  localparam int PC_ZEROS = 2;
  localparam int PC_LEN   = 32 - PC_ZEROS;
endpackage

// File: rtl/trap_ctrl_if.sv
// Execute-stage, CSR and redirect signals between the core and trap_ctrl.
interface trap_ctrl_if;
  import CoreConfig::*;
  import CSR_Pkg::*;

  logic              stall_n;
  logic              instr_valid;
  logic [PC_LEN-1:0] instr_pc;
  logic              exc_fetch_misaligned;
  logic              exc_illegal;
  logic              exc_ebreak;
  logic              exc_ecall;
  logic              is_mret;
  logic              csr_wreq;
  mstatus_t          csr_mstatus;
  mie_m_only_t       csr_mie;
  mip_m_only_t       csr_mip;
  mtvec_t            csr_mtvec;
  logic [PC_LEN-1:0] csr_mepc;

  logic              trap_occurred;
  logic              trap_returned;
  logic [PC_LEN-1:0] new_mepc;
  mcause_t           new_mcause;
  logic              instr_kill;
  logic              redirect_valid;
  logic [PC_LEN-1:0] redirect_pc;
  logic              flush;

  modport master (
    output stall_n, instr_valid, instr_pc, exc_fetch_misaligned, exc_illegal, exc_ebreak,
           exc_ecall, is_mret, csr_wreq, csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc,
    input  trap_occurred, trap_returned, new_mepc, new_mcause, instr_kill, redirect_valid,
           redirect_pc, flush
  );

  modport slave (
    input  stall_n, instr_valid, instr_pc, exc_fetch_misaligned, exc_illegal, exc_ebreak,
           exc_ecall, is_mret, csr_wreq, csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc,
    output trap_occurred, trap_returned, new_mepc, new_mcause, instr_kill, redirect_valid,
           redirect_pc, flush
  );
endinterface

// File: rtl/trap_cause_sel.sv
// Priority encoder choosing the winning trap cause and its vectored-mode byte offset.
module trap_cause_sel
  import CSR_Pkg::*;
(
  input  mie_m_only_t irq_active,
  input  logic        irq_enable,
  input  logic        exc_fetch_misaligned,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic [1:0]  tvec_mode,
  output logic        trap_hit,
  output mcause_t     cause,
  output logic [31:0] vec_offset
);

  always_comb begin
    trap_hit = 1'b0;
    cause    = '0;
    if (irq_enable && (|irq_active)) begin
      trap_hit   = 1'b1;
      cause.irq  = 1'b1;
      cause.code = irq_code(irq_active);
    end else if (exc_fetch_misaligned || exc_illegal || exc_ebreak || exc_ecall) begin
      trap_hit   = 1'b1;
      cause.code = exc_code(exc_fetch_misaligned, exc_illegal, exc_ebreak);
    end
  end

  // Reserved modes 2 and 3 fall back to direct mode.
  assign vec_offset = (cause.irq && tvec_mode == MTVEC_VECTORED) ? (32'(cause.code) << 2) : 32'd0;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret controller: picks the event, redirects the PC and holds the
// pipeline flushed for FLUSH_CYCLES advancing cycles afterwards.
module trap_ctrl
  import CoreConfig::*;
  import CSR_Pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_sync,
  trap_ctrl_if.slave  bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  trap_state_t state;
  logic [2:0]  flush_cnt;
  logic        accept;
  logic        trap_hit;
  logic        take_trap;
  logic        take_mret;
  mcause_t     cause;
  mie_m_only_t irq_active;
  logic [31:0] vec_offset;
  logic [31:0] target;
  logic        unused_ok;

  assign irq_active = bus.csr_mie & bus.csr_mip;

  trap_cause_sel u_cause_sel (
    .irq_active           (irq_active),
    .irq_enable           (bus.csr_mstatus.mie & ~bus.csr_wreq),
    .exc_fetch_misaligned (bus.exc_fetch_misaligned),
    .exc_illegal          (bus.exc_illegal),
    .exc_ebreak           (bus.exc_ebreak),
    .exc_ecall            (bus.exc_ecall),
    .tvec_mode            (bus.csr_mtvec.mode),
    .trap_hit             (trap_hit),
    .cause                (cause),
    .vec_offset           (vec_offset)
  );

  // Reset also masks events so no pulse escapes while it is held.
  assign accept    = (state == IDLE) && !rst_sync && bus.stall_n && bus.instr_valid;
  assign take_trap = accept && trap_hit;
  assign take_mret = accept && !trap_hit && bus.is_mret;
  assign target    = {bus.csr_mtvec.base, 2'b00} + vec_offset;

  assign bus.trap_occurred  = take_trap;
  assign bus.trap_returned  = take_mret;
  assign bus.instr_kill     = take_trap;
  assign bus.redirect_valid = take_trap || take_mret;
  assign bus.new_mepc       = take_trap ? bus.instr_pc : '0;
  assign bus.new_mcause     = take_trap ? cause : '0;
  assign bus.redirect_pc    = take_trap ? target[31:PC_ZEROS] :
                              take_mret ? bus.csr_mepc : '0;
  assign bus.flush          = (state == FLUSH);

  assign unused_ok = ^{target[PC_ZEROS-1:0], bus.csr_mstatus};

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap || take_mret) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (bus.stall_n) begin
            if (flush_cnt == 3'd0) state <= IDLE;
            else                   flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state     <= IDLE;
          flush_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: single-event vector table plus multi-cycle sequences.
module tb_trap_ctrl;
  import CSR_Pkg::*;

  logic clk;
  logic rst_sync;
  int   tests_run;
  int   tests_failed;

  trap_ctrl_if bus ();

  trap_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exc bits are {fetch_misaligned, illegal, ebreak, ecall}; mie/mip are {ext, timer, soft}.
  typedef struct {
    logic        stall_n;
    logic        valid;
    logic [29:0] pc;
    logic [3:0]  exc;
    logic        mret;
    logic        wreq;
    logic [31:0] mstatus;
    logic [2:0]  mie;
    logic [2:0]  mip;
    logic [31:0] mtvec;
    logic [29:0] mepc;
    logic        trap;
    logic        ret;
    logic        kill;
    logic        rv;
    logic [29:0] rpc;
    logic [29:0] nmepc;
    logic [31:0] cause;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.stall_n              = 1'b1;
    bus.instr_valid          = 1'b0;
    bus.instr_pc             = '0;
    bus.exc_fetch_misaligned = 1'b0;
    bus.exc_illegal          = 1'b0;
    bus.exc_ebreak           = 1'b0;
    bus.exc_ecall            = 1'b0;
    bus.is_mret              = 1'b0;
    bus.csr_wreq             = 1'b0;
    bus.csr_mstatus          = '0;
    bus.csr_mie              = '0;
    bus.csr_mip              = '0;
    bus.csr_mtvec            = '0;
    bus.csr_mepc             = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.stall_n              = v.stall_n;
    bus.instr_valid          = v.valid;
    bus.instr_pc             = v.pc;
    bus.exc_fetch_misaligned = v.exc[3];
    bus.exc_illegal          = v.exc[2];
    bus.exc_ebreak           = v.exc[1];
    bus.exc_ecall            = v.exc[0];
    bus.is_mret              = v.mret;
    bus.csr_wreq             = v.wreq;
    bus.csr_mstatus          = mstatus_t'(v.mstatus);
    bus.csr_mie              = mie_m_only_t'(v.mie);
    bus.csr_mip              = mip_m_only_t'(v.mip);
    bus.csr_mtvec            = mtvec_t'(v.mtvec);
    bus.csr_mepc             = v.mepc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //              stall valid pc      exc     mret wreq mstatus mie     mip     mtvec     mepc     trap ret kill rv rpc       nmepc    cause
    vecs[0]  = '{1, 1, 30'h40, 4'b0000, 0, 0, 32'h8, 3'b010, 3'b010, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h807, 30'h40, 32'h80000007};
    vecs[1]  = '{1, 1, 30'h10, 4'b0101, 0, 0, 32'h0, 3'b100, 3'b100, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h800, 30'h10, 32'h2};
    vecs[2]  = '{1, 1, 30'h20, 4'b0000, 1, 0, 32'h0, 3'b000, 3'b000, 32'h2001, 30'h55, 0, 1, 0, 1, 30'h55,  30'h0,  32'h0};
    vecs[3]  = '{0, 1, 30'h30, 4'b0100, 0, 0, 32'h8, 3'b111, 3'b111, 32'h2001, 30'h55, 0, 0, 0, 0, 30'h0,   30'h0,  32'h0};
    vecs[4]  = '{1, 0, 30'h30, 4'b0100, 1, 0, 32'h8, 3'b111, 3'b111, 32'h2001, 30'h55, 0, 0, 0, 0, 30'h0,   30'h0,  32'h0};
    vecs[5]  = '{1, 1, 30'h44, 4'b0000, 0, 0, 32'h8, 3'b111, 3'b111, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h80B, 30'h44, 32'h8000000B};
    vecs[6]  = '{1, 1, 30'h48, 4'b0000, 0, 0, 32'h8, 3'b011, 3'b011, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h803, 30'h48, 32'h80000003};
    vecs[7]  = '{1, 1, 30'h4C, 4'b0000, 0, 0, 32'h8, 3'b010, 3'b010, 32'h2003, 30'h0,  1, 0, 1, 1, 30'h800, 30'h4C, 32'h80000007};
    vecs[8]  = '{1, 1, 30'h50, 4'b0000, 0, 0, 32'h8, 3'b100, 3'b100, 32'h3000, 30'h0,  1, 0, 1, 1, 30'hC00, 30'h50, 32'h8000000B};
    vecs[9]  = '{1, 1, 30'h54, 4'b1111, 0, 0, 32'h0, 3'b000, 3'b000, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h800, 30'h54, 32'h0};
    vecs[10] = '{1, 1, 30'h58, 4'b0011, 0, 0, 32'h0, 3'b000, 3'b000, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h800, 30'h58, 32'h3};
    vecs[11] = '{1, 1, 30'h5C, 4'b0001, 0, 0, 32'h0, 3'b000, 3'b000, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h800, 30'h5C, 32'hB};
    vecs[12] = '{1, 1, 30'h60, 4'b0000, 1, 0, 32'h8, 3'b010, 3'b010, 32'h2001, 30'h55, 1, 0, 1, 1, 30'h807, 30'h60, 32'h80000007};
    vecs[13] = '{1, 1, 30'h64, 4'b0100, 1, 0, 32'h0, 3'b000, 3'b000, 32'h2001, 30'h55, 1, 0, 1, 1, 30'h800, 30'h64, 32'h2};
    vecs[14] = '{1, 1, 30'h68, 4'b0000, 0, 0, 32'h8, 3'b001, 3'b100, 32'h2001, 30'h0,  0, 0, 0, 0, 30'h0,   30'h0,  32'h0};
    vecs[15] = '{1, 1, 30'h6C, 4'b0100, 0, 1, 32'h8, 3'b100, 3'b100, 32'h2001, 30'h0,  1, 0, 1, 1, 30'h800, 30'h6C, 32'h2};
    vecs[16] = '{1, 1, 30'h70, 4'b0000, 0, 0, 32'h8, 3'b001, 3'b001, 32'h2002, 30'h0,  1, 0, 1, 1, 30'h800, 30'h70, 32'h80000003};

    // Reset with a live exception on the inputs: nothing may leak out.
    clearInputs();
    rst_sync = 1'b1;
    bus.instr_valid = 1'b1;
    bus.exc_illegal = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_flush", 32'(bus.flush), 32'h0);
    checkOutput("reset_trap", 32'(bus.trap_occurred), 32'h0);
    checkOutput("reset_redirect", 32'(bus.redirect_valid), 32'h0);
    checkOutput("reset_cause", 32'(bus.new_mcause), 32'h0);
    @(negedge clk);
    rst_sync = 1'b0;
    clearInputs();

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_trap", i), 32'(bus.trap_occurred), 32'(vecs[i].trap));
      checkOutput($sformatf("v%0d_ret", i), 32'(bus.trap_returned), 32'(vecs[i].ret));
      checkOutput($sformatf("v%0d_kill", i), 32'(bus.instr_kill), 32'(vecs[i].kill));
      checkOutput($sformatf("v%0d_rv", i), 32'(bus.redirect_valid), 32'(vecs[i].rv));
      checkOutput($sformatf("v%0d_rpc", i), 32'(bus.redirect_pc), 32'(vecs[i].rpc));
      checkOutput($sformatf("v%0d_mepc", i), 32'(bus.new_mepc), 32'(vecs[i].nmepc));
      checkOutput($sformatf("v%0d_cause", i), 32'(bus.new_mcause), vecs[i].cause);
      @(negedge clk);
      clearInputs();
      #2;
      checkOutput($sformatf("v%0d_flush1", i), 32'(bus.flush), 32'(vecs[i].rv));
      @(negedge clk);
      #2;
      checkOutput($sformatf("v%0d_flush2", i), 32'(bus.flush), 32'(vecs[i].rv));
      @(negedge clk);
      #2;
      checkOutput($sformatf("v%0d_flush_end", i), 32'(bus.flush), 32'h0);
    end

    // mret followed by one stalled cycle: flush stretches to three cycles.
    @(negedge clk);
    clearInputs();
    bus.instr_valid = 1'b1;
    bus.is_mret     = 1'b1;
    bus.csr_mepc    = 30'h55;
    #2;
    checkOutput("mret_ret", 32'(bus.trap_returned), 32'h1);
    checkOutput("mret_rpc", 32'(bus.redirect_pc), 32'h55);
    @(negedge clk);
    clearInputs();
    bus.stall_n = 1'b0;
    #2;
    checkOutput("mret_flush_stall", 32'(bus.flush), 32'h1);
    @(negedge clk);
    clearInputs();
    bus.instr_valid = 1'b1;
    bus.exc_illegal = 1'b1;
    #2;
    checkOutput("mret_flush_a", 32'(bus.flush), 32'h1);
    checkOutput("mret_flush_no_trap", 32'(bus.trap_occurred), 32'h0);
    checkOutput("mret_flush_no_kill", 32'(bus.instr_kill), 32'h0);
    @(negedge clk);
    clearInputs();
    #2;
    checkOutput("mret_flush_b", 32'(bus.flush), 32'h1);
    @(negedge clk);
    #2;
    checkOutput("mret_flush_end", 32'(bus.flush), 32'h0);

    // Interrupt deferred by a CSR write, taken on the next clean instruction.
    @(negedge clk);
    clearInputs();
    bus.instr_valid = 1'b1;
    bus.instr_pc    = 30'h80;
    bus.csr_mstatus = mstatus_t'(32'h8);
    bus.csr_mie     = mie_m_only_t'(3'b100);
    bus.csr_mip     = mip_m_only_t'(3'b100);
    bus.csr_mtvec   = mtvec_t'(32'h2001);
    bus.csr_wreq    = 1'b1;
    #2;
    checkOutput("defer_trap", 32'(bus.trap_occurred), 32'h0);
    checkOutput("defer_kill", 32'(bus.instr_kill), 32'h0);
    checkOutput("defer_rv", 32'(bus.redirect_valid), 32'h0);
    @(negedge clk);
    bus.csr_wreq = 1'b0;
    bus.instr_pc = 30'h84;
    #2;
    checkOutput("defer_no_flush", 32'(bus.flush), 32'h0);
    checkOutput("defer_take", 32'(bus.trap_occurred), 32'h1);
    checkOutput("defer_cause", 32'(bus.new_mcause), 32'h8000000B);
    checkOutput("defer_mepc", 32'(bus.new_mepc), 32'h84);
    repeat (3) begin
      @(negedge clk);
      clearInputs();
    end

    // Second exception during flush is ignored; reset mid-flush returns to IDLE.
    @(negedge clk);
    clearInputs();
    bus.instr_valid = 1'b1;
    bus.instr_pc    = 30'h90;
    bus.exc_illegal = 1'b1;
    #2;
    checkOutput("midrst_trap", 32'(bus.trap_occurred), 32'h1);
    @(negedge clk);
    clearInputs();
    bus.instr_valid = 1'b1;
    bus.instr_pc    = 30'h94;
    bus.exc_ecall   = 1'b1;
    #2;
    checkOutput("midrst_flush", 32'(bus.flush), 32'h1);
    checkOutput("midrst_ignore_trap", 32'(bus.trap_occurred), 32'h0);
    checkOutput("midrst_ignore_kill", 32'(bus.instr_kill), 32'h0);
    checkOutput("midrst_ignore_rv", 32'(bus.redirect_valid), 32'h0);
    checkOutput("midrst_ignore_cause", 32'(bus.new_mcause), 32'h0);
    rst_sync = 1'b1;
    @(negedge clk);
    rst_sync = 1'b0;
    clearInputs();
    #2;
    checkOutput("midrst_flush_clear", 32'(bus.flush), 32'h0);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_pc    = 30'h98;
    bus.exc_illegal = 1'b1;
    #2;
    checkOutput("midrst_idle_trap", 32'(bus.trap_occurred), 32'h1);
    checkOutput("midrst_idle_cause", 32'(bus.new_mcause), 32'h2);
    @(negedge clk);
    clearInputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning: cycles the pipeline is held flushed after a redirect (range 1..7).
REQ-002 SHALL have port clk  input  1  core clock; single clock domain.
REQ-003 SHALL have port rst_sync  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_n  input  1  pipeline advance; events are evaluated only when 1.
REQ-005 SHALL have port instr_valid  input  1  execute stage holds a real instruction.
REQ-006 SHALL have port instr_pc  input  PC_LEN  PC of the execute-stage instruction, PC_ZEROS stripped.
REQ-007 SHALL have port exc_fetch_misaligned, exc_illegal, exc_ebreak, exc_ecall, is_mret  input  1 each  decode flags.
REQ-008 SHALL have port csr_wreq  input  1  ungated CSR write request of the execute-stage instruction.
REQ-009 SHALL have port csr_mstatus  input  mstatus_t; csr_mie  input  mie_m_only_t; csr_mip  input  mip_m_only_t; csr_mtvec  input  mtvec_t; csr_mepc  input  PC_LEN.
REQ-010 SHALL have port trap_occurred, trap_returned  output  1  one-cycle pulses to the CSR file.
REQ-011 SHALL have port new_mepc  output  PC_LEN; new_mcause  output  mcause_t.
REQ-012 SHALL have port instr_kill  output  1  combinational; the core gates CSR write and register writeback with it.
REQ-013 SHALL have port redirect_valid  output  1, redirect_pc  output  PC_LEN, flush  output  1.

Function
REQ-014 SHALL implement states IDLE and FLUSH plus a 3-bit flush counter.
REQ-015 In IDLE, a candidate event SHALL exist only when stall_n=1 and instr_valid=1.
REQ-016 The interrupt candidate SHALL be mstatus.mie=1 and |(mie&mip) and csr_wreq=0; with csr_wreq=1 it SHALL be deferred, not lost.
REQ-017 Priority SHALL be interrupt > exception > mret; interrupts MEI(11) > MSI(3) > MTI(7); exceptions fetch_misaligned(0) > illegal(2) > ebreak(3) > ecall(11).
REQ-018 On trap, in the same cycle: trap_occurred=1, instr_kill=1, new_mepc=instr_pc, new_mcause={interrupt bit, code}, redirect_valid=1.
REQ-019 On mret with no higher event: trap_returned=1, instr_kill=0, redirect_valid=1, redirect_pc=csr_mepc.
REQ-020 Trap target SHALL be the byte address {mtvec.base,2'b00} for exceptions or when mode=0; {base,2'b00}+4*code for interrupts with mode=1; computed at 32 bits, then bits [31:PC_ZEROS] are driven.
REQ-021 mtvec mode values 2 and 3 SHALL be treated as 0.
REQ-022 Any redirect SHALL move IDLE->FLUSH with the counter loaded to FLUSH_CYCLES-1; flush=1 throughout FLUSH.
REQ-023 In FLUSH, the counter SHALL decrement only when stall_n=1; at 0 with stall_n=1 the block SHALL return to IDLE.
REQ-024 In FLUSH, no event SHALL be accepted, and trap_occurred, trap_returned, redirect_valid and instr_kill SHALL all be 0.
REQ-025 When stall_n=0 in IDLE, all pulses and instr_kill SHALL be 0.
REQ-026 Outside their pulse cycles, new_mepc, new_mcause and redirect_pc SHALL be 0.

Reset
REQ-027 rst_sync=1 SHALL force IDLE, counter=0, and all outputs 0 on the next edge, including when it arrives mid-FLUSH.
REQ-028 No output SHALL depend on power-up register values before the first reset.

Structure
REQ-029 Cause codes, trap_state_t, and the interrupt/exception priority order SHALL live in CSR_Pkg; PC_LEN and PC_ZEROS SHALL come from CoreConfig.
REQ-030 One combinational sub-module, trap_cause_sel (priority encoder producing the mcause and the vectored offset), is natural; the state machine stays in trap_ctrl.

Verification
REQ-031 mie=1, mie.MTI=1, mip.MTI=1, instr_pc=0x40 (bytes 0x100), mtvec=0x2001 (vectored) -> trap_occurred, new_mcause=0x80000007, new_mepc=0x40, redirect byte addr 0x201C.
REQ-032 exc_illegal=1, exc_ecall=1, MEI pending with mstatus.mie=0 -> mcause=2, target = mtvec base; interrupt ignored.
REQ-033 is_mret=1, csr_mepc=0x55 -> trap_returned, redirect_pc=0x55, flush held for 2 advancing cycles; a stall_n=0 cycle extends the flush to 3 cycles.
REQ-034 MEI pending with csr_wreq=1 -> no trap and instr_kill=0; on the next valid instruction with csr_wreq=0 -> trap with mcause=0x8000000B.
REQ-035 Exception accepted, then a second exception presented during FLUSH -> ignored; rst_sync=1 mid-FLUSH -> flush=0 on the next cycle and state IDLE.
